// File: rtl/count_seq_pkg.sv
// Shared types and successor helpers for the 5-bit up/down wrap counter stream.
package count_seq_pkg;

    localparam int unsigned DEF_WIDTH   = 5;
    localparam int unsigned DEF_MAX_VAL = 30;

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    function automatic int unsigned up_succ(input int unsigned v, input int unsigned max_val);
        return (v == max_val) ? 32'd0 : v + 32'd1;
    endfunction

    function automatic int unsigned dn_succ(input int unsigned v, input int unsigned max_val);
        return (v == 32'd0) ? max_val : v - 32'd1;
    endfunction

endpackage

// File: rtl/count_step_calc.sv
// Classifies a sample against the previous one: up step, down step, and range legality.
module count_step_calc
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MAX_VAL = DEF_MAX_VAL
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] sample,
    output logic             is_up,
    output logic             is_dn,
    output logic             in_range
);

    always_comb begin
        is_up    = (32'(sample) == up_succ(32'(prev), MAX_VAL));
        is_dn    = (32'(sample) == dn_succ(32'(prev), MAX_VAL));
        in_range = (32'(sample) <= MAX_VAL);
    end

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side monitor: locks onto the counter's direction, flags sequence/range errors and counts them.
module count_seq_checker
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned MAX_VAL    = DEF_MAX_VAL,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     sample,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 dir,
    output logic [WIDTH-1:0]     expect_val,
    output logic                 err_pulse,
    output logic                 range_err,
    output logic                 dir_change,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);

    state_t               state, state_n;
    logic [WIDTH-1:0]     prev, prev_n;
    logic [MC_W-1:0]      match_cnt, match_cnt_n;
    logic                 cand_dir, cand_dir_n;
    logic                 locked_n, dir_n, err_n, range_n, dchg_n;
    logic [ERR_CNT_W-1:0] err_count_n;
    logic                 is_up, is_dn, in_range;
    logic                 fwd, rev;

    count_step_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step (
        .prev     (prev),
        .sample   (sample),
        .is_up    (is_up),
        .is_dn    (is_dn),
        .in_range (in_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= '0;
            match_cnt  <= '0;
            cand_dir   <= 1'b0;
            locked     <= 1'b0;
            dir        <= 1'b0;
            err_pulse  <= 1'b0;
            range_err  <= 1'b0;
            dir_change <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            match_cnt  <= match_cnt_n;
            cand_dir   <= cand_dir_n;
            locked     <= locked_n;
            dir        <= dir_n;
            err_pulse  <= err_n;
            range_err  <= range_n;
            dir_change <= dchg_n;
            err_count  <= err_count_n;
        end
    end

    always_comb begin
        state_n     = state;
        prev_n      = prev;
        match_cnt_n = match_cnt;
        cand_dir_n  = cand_dir;
        locked_n    = locked;
        dir_n       = dir;
        err_n       = 1'b0;
        range_n     = 1'b0;
        dchg_n      = 1'b0;
        fwd         = dir ? is_up : is_dn;
        rev         = dir ? is_dn : is_up;

        if (sample_valid) begin
            if (!in_range) begin
                err_n       = 1'b1;
                range_n     = 1'b1;
                state_n     = IDLE;
                match_cnt_n = '0;
                locked_n    = 1'b0;
            end else begin
                prev_n = sample;
                case (state)
                    IDLE: begin
                        match_cnt_n = '0;
                        state_n     = ACQUIRE;
                    end
                    ACQUIRE: begin
                        // A step against the current candidate direction restarts the run at 1.
                        if (is_up || is_dn) begin
                            if (match_cnt != '0 && cand_dir != is_up)
                                match_cnt_n = MC_W'(1);
                            else
                                match_cnt_n = match_cnt + MC_W'(1);
                            cand_dir_n = is_up;
                        end else begin
                            match_cnt_n = '0;
                        end
                        if (match_cnt_n == MC_W'(LOCK_COUNT)) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            dir_n    = cand_dir_n;
                        end
                    end
                    LOCKED: begin
                        if (!fwd) begin
                            if (rev) begin
                                dir_n  = ~dir;
                                dchg_n = 1'b1;
                            end else begin
                                err_n       = 1'b1;
                                locked_n    = 1'b0;
                                state_n     = ACQUIRE;
                                match_cnt_n = '0;
                            end
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        err_count_n = err_count;
        if (err_clr)
            err_count_n = err_n ? ERR_CNT_W'(1) : '0;
        else if (err_n && err_count != '1)
            err_count_n = err_count + ERR_CNT_W'(1);
    end

    always_comb begin
        expect_val = '0;
        if (locked)
            expect_val = dir ? WIDTH'(up_succ(32'(prev), MAX_VAL))
                             : WIDTH'(dn_succ(32'(prev), MAX_VAL));
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: default instance plus a 2-bit error counter instance.
module tb_count_seq_checker;

    typedef struct packed {
        logic       lk;
        logic       dr;
        logic [4:0] ev;
        logic       er;
        logic       rg;
        logic       dc;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, c1, v2, c2;
    logic [4:0] s1, s2;
    logic       l1, d1, e1, r1, dc1;
    logic       l2, d2, e2, r2, dc2;
    logic [4:0] ev1, ev2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    obs_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    count_seq_checker dut (
        .clk(clk), .rst(rst), .sample_valid(v1), .sample(s1), .err_clr(c1),
        .locked(l1), .dir(d1), .expect_val(ev1), .err_pulse(e1),
        .range_err(r1), .dir_change(dc1), .err_count(cnt1)
    );

    count_seq_checker #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .sample_valid(v2), .sample(s2), .err_clr(c2),
        .locked(l2), .dir(d2), .expect_val(ev2), .err_pulse(e2),
        .range_err(r2), .dir_change(dc2), .err_count(cnt2)
    );

    function automatic obs_t mk(input logic lk, input logic dr, input logic [4:0] ev,
                                input logic er, input logic rg, input logic dc,
                                input logic [7:0] cnt);
        obs_t o;
        o.lk = lk; o.dr = dr; o.ev = ev; o.er = er; o.rg = rg; o.dc = dc; o.cnt = cnt;
        return o;
    endfunction

    function automatic obs_t obs(input bit which);
        if (which)
            return mk(l2, d2, ev2, e2, r2, dc2, {6'b0, cnt2});
        return mk(l1, d1, ev1, e1, r1, dc1, cnt1);
    endfunction

    task automatic step(input bit which, input logic v, input logic [4:0] s, input logic c);
        @(negedge clk);
        v1 = 1'b0; c1 = 1'b0; v2 = 1'b0; c2 = 1'b0;
        if (which) begin v2 = v; s2 = s; c2 = c; end
        else       begin v1 = v; s1 = s; c1 = c; end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        obs_t got, exp;
        rst = 1'b1; v1 = 1'b0; c1 = 1'b0; s1 = '0; v2 = 1'b0; c2 = 1'b0; s2 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            got = obs(w[0]);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL reset[%0d] got=%h exp=%h", w, got, exp);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock_up;
        logic [4:0] smp [8];
        obs_t ex [8];
        obs_t got, exp;
        smp = '{5'd27, 5'd28, 5'd29, 5'd30, 5'd0, 5'd1, 5'd2, 5'd3};
        for (int i = 0; i < 4; i++) ex[i] = mk(0, 0, 0, 0, 0, 0, 0);
        ex[4] = mk(1, 1, 1, 0, 0, 0, 0);
        ex[5] = mk(1, 1, 2, 0, 0, 0, 0);
        ex[6] = mk(1, 1, 3, 0, 0, 0, 0);
        ex[7] = mk(1, 1, 4, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            sbq.push_back(ex[i]);
            step(0, 1'b1, smp[i], 1'b0);
            got = obs(0);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL lock_up[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_dir_change;
        logic [4:0] smp [4];
        obs_t ex [4];
        obs_t got, exp;
        smp = '{5'd4, 5'd5, 5'd4, 5'd3};
        ex[0] = mk(1, 1, 5, 0, 0, 0, 0);
        ex[1] = mk(1, 1, 6, 0, 0, 0, 0);
        ex[2] = mk(1, 0, 3, 0, 0, 1, 0);
        ex[3] = mk(1, 0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            sbq.push_back(ex[i]);
            step(0, 1'b1, smp[i], 1'b0);
            got = obs(0);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL dir_change[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_seq_error;
        logic [4:0] smp [9];
        obs_t ex [9];
        obs_t got, exp;
        smp = '{5'd2, 5'd1, 5'd0, 5'd30, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13};
        ex[0] = mk(1, 0, 1, 0, 0, 0, 0);
        ex[1] = mk(1, 0, 0, 0, 0, 0, 0);
        ex[2] = mk(1, 0, 30, 0, 0, 0, 0);
        ex[3] = mk(1, 0, 29, 0, 0, 0, 0);
        ex[4] = mk(0, 0, 0, 1, 0, 0, 1);
        for (int i = 5; i < 8; i++) ex[i] = mk(0, 0, 0, 0, 0, 0, 1);
        ex[8] = mk(1, 0, 12, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            sbq.push_back(ex[i]);
            step(0, 1'b1, smp[i], 1'b0);
            got = obs(0);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL seq_error[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_range;
        logic [4:0] smp [4];
        obs_t ex [4];
        obs_t got, exp;
        smp = '{5'd31, 5'd31, 5'd5, 5'd30};
        ex[0] = mk(0, 0, 0, 1, 1, 0, 2);
        ex[1] = mk(0, 0, 0, 1, 1, 0, 3);
        ex[2] = mk(0, 0, 0, 0, 0, 0, 3);
        ex[3] = mk(0, 0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            sbq.push_back(ex[i]);
            step(0, 1'b1, smp[i], 1'b0);
            got = obs(0);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL range[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_err_saturate;
        obs_t got, exp;
        for (int i = 0; i < 7; i++) begin
            logic [7:0] c;
            c = (i < 3) ? 8'(i + 1) : 8'd3;
            if (i == 5) c = 8'd1;
            if (i == 6) sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            else        sbq.push_back(mk(0, 0, 0, 1, 1, 0, c));
            step(1, (i != 6), 5'd31, (i >= 5));
            got = obs(1);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL err_sat[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        obs_t got, exp;
        logic [4:0] smp [4];
        smp = '{5'd29, 5'd28, 5'd27, 5'd26};
        for (int i = 0; i < 4; i++) begin
            sbq.push_back((i == 3) ? mk(1, 0, 25, 0, 0, 0, 3) : mk(0, 0, 0, 0, 0, 0, 3));
            step(0, 1'b1, smp[i], 1'b0);
            got = obs(0);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL relock_dn[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
        // Invalid cycles carry an out-of-range value that must be ignored.
        for (int i = 0; i < 12; i++) begin
            if (i < 10)       sbq.push_back(mk(1, 0, 25, 0, 0, 0, 3));
            else if (i == 10) sbq.push_back(mk(1, 0, 24, 0, 0, 0, 3));
            else              sbq.push_back(mk(1, 0, 24, 0, 0, 0, 0));
            step(0, (i == 10), (i == 10) ? 5'd25 : 5'd31, (i == 11));
            got = obs(0);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL idle_hold[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_mid_reset;
        obs_t got, exp;
        #2 rst = 1'b1;
        #1;
        sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        got = obs(0);
        exp = sbq.pop_front();
        total++;
        if (got !== exp) $display("FAIL mid_reset got=%h exp=%h", got, exp);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sbq.push_back((i == 4) ? mk(1, 1, 12, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0));
            step(0, 1'b1, 5'(7 + i), 1'b0);
            got = obs(0);
            exp = sbq.pop_front();
            total++;
            if (got !== exp) $display("FAIL post_reset[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_dir_change();
        test_seq_error();
        test_range();
        test_err_saturate();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
